// File: rtl/fma16_pkg.sv
// fma16_pkg
// Shared types and constants for the fma16 scheduler and its datapath.
//   fma_ctl_t   : {mul, add, negp, negz} operation control
//   fma_flags_t : {NV, OF, UF, NX} IEEE exception flags
//   rm_t        : rounding mode
//   occ_t       : pipeline occupancy (EMPTY / ONE / FULL), exported for debug
//   pri_t       : round-robin priority holder
package fma16_pkg;

    localparam int FP16_W = 16;

    typedef struct packed {
        logic mul;
        logic add;
        logic negp;
        logic negz;
    } fma_ctl_t;

    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } fma_flags_t;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RDN = 2'd2,
        RM_RUP = 2'd3
    } rm_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    typedef enum logic {
        PRI_0 = 1'b0,
        PRI_1 = 1'b1
    } pri_t;

endpackage

// File: rtl/fma_sched_if.sv
// fma_sched_if
// Request and result buses of the fma16 scheduler.
//   req_valid/req_ready [2]     : per-requester operation handshake
//   req_x/y/z, req_ctl, req_rm  : per-requester operands, control, rounding mode
//   res_valid/res_ready         : result handshake
//   res_data, res_tag, res_flags: result value, originating requester, flags
// Modports: master = requesters plus result consumer, slave = scheduler.
//
// Handshake rule for every valid/ready pair on this bus: a transfer happens on
// a rising clock edge where valid and ready are both high. A producer raising
// valid holds it and its data unchanged until that transfer, and valid/data
// never depend combinationally on the same pair's ready.
interface fma_sched_if;
    import fma16_pkg::*;

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][FP16_W-1:0] req_x;
    logic [1:0][FP16_W-1:0] req_y;
    logic [1:0][FP16_W-1:0] req_z;
    fma_ctl_t [1:0]         req_ctl;
    logic [1:0][1:0]        req_rm;

    logic                   res_valid;
    logic                   res_ready;
    logic [FP16_W-1:0]      res_data;
    logic                   res_tag;
    fma_flags_t             res_flags;

    modport master (
        output req_valid, req_x, req_y, req_z, req_ctl, req_rm, res_ready,
        input  req_ready, res_valid, res_data, res_tag, res_flags
    );

    modport slave (
        input  req_valid, req_x, req_y, req_z, req_ctl, req_rm, res_ready,
        output req_ready, res_valid, res_data, res_tag, res_flags
    );

endinterface

// File: rtl/fma_rr_arb.sv
// fma_rr_arb
// Two-requester round-robin arbiter.
//   clk, reset_n : clock, asynchronous active-low reset
//   req[2]       : requests
//   advance      : downstream slot can take an operation this cycle
//   grant[2]     : one-hot grant, zero when advance is low
//   prio         : current priority holder (debug view of the state)
// Priority only rotates when both requesters compete and a grant is issued;
// a lone requester is served without disturbing the priority.
module fma_rr_arb
    import fma16_pkg::*;
#(
    parameter int RR_INIT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output pri_t       prio
);

    localparam pri_t PRI_RST = (RR_INIT == 0) ? PRI_0 : PRI_1;

    pri_t prio_q;
    pri_t prio_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= PRI_RST;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        grant  = 2'b00;
        prio_d = prio_q;
        if (advance) begin
            case (req)
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
                2'b11: begin
                    if (prio_q == PRI_0) begin
                        grant  = 2'b01;
                        prio_d = PRI_1;
                    end else begin
                        grant  = 2'b10;
                        prio_d = PRI_0;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign prio = prio_q;

endmodule

// File: rtl/fma_sched.sv
// fma_sched
// Two-requester scheduler in front of a combinational fma16 datapath.
// Stage S0 registers the granted operation and drives dp_* directly;
// stage S1 registers dp_result/dp_flags together with the requester tag.
//   clk, reset_n         : clock, asynchronous active-low reset
//   bus (slave)          : request and result handshakes (fma_sched_if)
//   dp_x/y/z, dp_ctl/rm  : operands to the datapath (0 while S0 is empty)
//   dp_result, dp_flags  : datapath response
//   sticky_flags[2]      : per-requester accumulated flags
//   flags_clr[2]         : per-requester sticky clear
//   occ                  : occupancy EMPTY/ONE/FULL (debug)
//   prio                 : round-robin priority holder (debug)
// Build option: define FMA_SCHED_STICKY_EN to keep sticky flag registers;
// without it sticky_flags is tied to 0 and flags_clr is ignored.
module fma_sched
    import fma16_pkg::*;
#(
    parameter int RR_INIT = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    fma_sched_if.slave          bus,
    output logic [FP16_W-1:0]   dp_x,
    output logic [FP16_W-1:0]   dp_y,
    output logic [FP16_W-1:0]   dp_z,
    output fma_ctl_t            dp_ctl,
    output logic [1:0]          dp_rm,
    input  logic [FP16_W-1:0]   dp_result,
    input  fma_flags_t          dp_flags,
    output fma_flags_t [1:0]    sticky_flags,
    input  logic [1:0]          flags_clr,
    output occ_t                occ,
    output pri_t                prio
);

    logic              s0_valid;
    logic              s0_tag;
    logic [FP16_W-1:0] s0_x;
    logic [FP16_W-1:0] s0_y;
    logic [FP16_W-1:0] s0_z;
    fma_ctl_t          s0_ctl;
    logic [1:0]        s0_rm;

    logic              s1_valid;
    logic              s1_tag;
    logic [FP16_W-1:0] s1_data;
    fma_flags_t        s1_flags;

    logic              s1_adv;
    logic              s0_adv;
    logic [1:0]        grant;
    logic              accept;
    logic              sel;

    assign s1_adv = ~s1_valid | bus.res_ready;
    assign s0_adv = ~s0_valid | s1_adv;

    // reset_n gates the arbiter so no req_ready is offered while in reset.
    fma_rr_arb #(
        .RR_INIT (RR_INIT)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .advance (s0_adv & reset_n),
        .grant   (grant),
        .prio    (prio)
    );

    assign accept        = |grant;
    assign sel           = grant[1];
    assign bus.req_ready = grant;

    // S0: an advancing slot with no new operation is loaded with zeros so the
    // datapath sees 0 whenever the stage is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_tag   <= 1'b0;
            s0_x     <= '0;
            s0_y     <= '0;
            s0_z     <= '0;
            s0_ctl   <= '0;
            s0_rm    <= '0;
        end else if (s0_adv) begin
            s0_valid <= accept;
            s0_tag   <= accept & sel;
            s0_x     <= accept ? bus.req_x[sel]   : '0;
            s0_y     <= accept ? bus.req_y[sel]   : '0;
            s0_z     <= accept ? bus.req_z[sel]   : '0;
            s0_ctl   <= accept ? bus.req_ctl[sel] : '0;
            s0_rm    <= accept ? bus.req_rm[sel]  : '0;
        end
    end

    assign dp_x   = s0_x;
    assign dp_y   = s0_y;
    assign dp_z   = s0_z;
    assign dp_ctl = s0_ctl;
    assign dp_rm  = s0_rm;

    // S1 captures the datapath response of the operation sitting in S0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_data  <= '0;
            s1_flags <= '0;
        end else if (s1_adv) begin
            s1_valid <= s0_valid;
            s1_tag   <= s0_valid & s0_tag;
            s1_data  <= s0_valid ? dp_result : '0;
            s1_flags <= s0_valid ? dp_flags  : '0;
        end
    end

    assign bus.res_valid = s1_valid;
    assign bus.res_data  = s1_data;
    assign bus.res_tag   = s1_tag;
    assign bus.res_flags = s1_flags;

    always_comb begin
        case ({s0_valid, s1_valid})
            2'b00:   occ = OCC_EMPTY;
            2'b11:   occ = OCC_FULL;
            default: occ = OCC_ONE;
        endcase
    end

`ifdef FMA_SCHED_STICKY_EN
    fma_flags_t [1:0] sticky_q;
    fma_flags_t [1:0] sticky_d;
    logic             res_hs;

    assign res_hs = s1_valid & bus.res_ready;

    // Clear first, then OR in the retiring flags, so a clear coinciding with
    // a retire leaves exactly that retire's flags.
    always_comb begin
        sticky_d = sticky_q;
        for (int i = 0; i < 2; i++) begin
            if (flags_clr[i]) begin
                sticky_d[i] = '0;
            end
            if (res_hs && (s1_tag == 1'(i))) begin
                sticky_d[i] = sticky_d[i] | s1_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_clr;
    assign unused_clr   = ^flags_clr;
    assign sticky_flags = '0;
`endif

endmodule

// File: tb/tb_fma_sched.sv
// tb_fma_sched
// Bench for fma_sched. A stand-in combinational datapath returns the fp16
// answers for the known operand sets and a fixed scramble otherwise. The
// reference model treats the scheduler as a two-slot FIFO with round-robin
// admission; expected results are queued at admission and popped by a
// separate result monitor.
module tb_fma_sched;
    import fma16_pkg::*;

    localparam int EW = 53; // {accept_edge[31:0], tag, flags[3:0], data[15:0]}

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fma_sched_if bus();

    logic [15:0]      dp_x, dp_y, dp_z, dp_result;
    fma_ctl_t         dp_ctl;
    logic [1:0]       dp_rm;
    fma_flags_t       dp_flags;
    fma_flags_t [1:0] sticky_flags;
    logic [1:0]       flags_clr;
    occ_t             occ;
    pri_t             prio;

    fma_sched #(.RR_INIT(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .dp_x         (dp_x),
        .dp_y         (dp_y),
        .dp_z         (dp_z),
        .dp_ctl       (dp_ctl),
        .dp_rm        (dp_rm),
        .dp_result    (dp_result),
        .dp_flags     (dp_flags),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr),
        .occ          (occ),
        .prio         (prio)
    );

    // Stand-in datapath: {flags, result}.
    function automatic logic [19:0] dp_fn(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z, input logic [3:0] c,
                                          input logic [1:0] rm);
        logic [15:0] d;
        logic [3:0]  f;
        if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && c == 4'b1100) begin
            d = 16'h4200;
            f = 4'b0000;
        end else if (x == 16'h7BFF && y == 16'h4000 && z == 16'h0000 && c == 4'b1100) begin
            d = 16'h7C00;
            f = 4'b0101;
        end else begin
            d = (x ^ {y[7:0], y[15:8]}) + z + {8'h00, c, 2'b00, rm};
            f = d[15:12] ^ x[3:0];
        end
        return {f, d};
    endfunction

    assign {dp_flags, dp_result} = dp_fn(dp_x, dp_y, dp_z, dp_ctl, dp_rm);

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            edge_cnt = 0;
    int            prio_m = 0;
    logic [3:0]    sticky_m[2];
    logic [1:0]    last_acc = 2'b00;
    int            acc_cnt = 0;
    int            last_lat = 0;
    logic [15:0]   last_data = '0;
    int            retired_tags[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z, input logic [3:0] c, input logic [1:0] rm);
        bus.req_x[i]   = x;
        bus.req_y[i]   = y;
        bus.req_z[i]   = z;
        bus.req_ctl[i] = c;
        bus.req_rm[i]  = rm;
    endtask

    task automatic rand_op(input int i);
        set_op(i, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 2'($urandom));
    endtask

    // Called right after a falling edge with inputs applied; checks the
    // admission side against the model, queues admitted ops, returns at the
    // next falling edge.
    task automatic tick();
        logic [1:0] eg;
        int         occn;
        logic       can;
        logic [1:0] occ_e;
        #1;
        last_acc = 2'b00;
        if (reset_n) begin
            occn  = exp_q.size();
            can   = (occn < 2) || bus.res_ready;
            eg    = 2'b00;
            if (can) begin
                case (bus.req_valid)
                    2'b01:   eg = 2'b01;
                    2'b10:   eg = 2'b10;
                    2'b11:   eg = (prio_m == 0) ? 2'b01 : 2'b10;
                    default: eg = 2'b00;
                endcase
            end
            occ_e = (occn == 0) ? 2'd0 : (occn == 1) ? 2'd1 : 2'd2;
            check("req_ready", 64'(bus.req_ready), 64'(eg));
            check("occ", 64'(occ), 64'(occ_e));
            check("prio", 64'(prio), 64'(prio_m));
            if (occn == 0 || (occn == 1 && bus.res_valid))
                check("dp_idle", 64'({dp_x, dp_y, dp_z}), 64'(0));
            if (bus.req_valid == 2'b11 && can) prio_m = 1 - prio_m;
            for (int i = 0; i < 2; i++) begin
                if (eg[i]) begin
                    exp_q.push_back({32'(edge_cnt + 1), 1'(i),
                                     dp_fn(bus.req_x[i], bus.req_y[i], bus.req_z[i],
                                           bus.req_ctl[i], bus.req_rm[i])});
                    acc_cnt++;
                end
            end
            last_acc = eg;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.req_valid = 2'b00;
        bus.res_ready = 1'b1;
        flags_clr     = 2'b00;
        while (exp_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        tick();
        check(name, 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- result monitor ----------------
    initial begin
        logic          stall_prev;
        logic          dp_hold_prev;
        logic [20:0]   held_prev;
        logic [53:0]   dp_prev;
        logic [EW-1:0] e;
        logic          hs;
        int            lat;
        stall_prev   = 1'b0;
        dp_hold_prev = 1'b0;
        held_prev    = '0;
        dp_prev      = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                stall_prev   = 1'b0;
                dp_hold_prev = 1'b0;
            end else begin
                check("sticky0", 64'(sticky_flags[0]), 64'(sticky_m[0]));
                check("sticky1", 64'(sticky_flags[1]), 64'(sticky_m[1]));
                if (stall_prev) begin
                    check("hold_valid", 64'(bus.res_valid), 64'(1));
                    check("hold_res", 64'({bus.res_data, bus.res_tag, bus.res_flags}), 64'(held_prev));
                end
                if (dp_hold_prev)
                    check("hold_dp", 64'({dp_x, dp_y, dp_z, dp_ctl, dp_rm}), 64'(dp_prev));
                hs = bus.res_valid && bus.res_ready;
                e  = '0;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got data %h tag %0d with nothing outstanding",
                                 bus.res_data, bus.res_tag);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", 64'(bus.res_data), 64'(e[15:0]));
                        check("res_flags", 64'(bus.res_flags), 64'(e[19:16]));
                        check("res_tag", 64'(bus.res_tag), 64'(e[20]));
                        lat = edge_cnt + 1 - int'(e[52:21]);
                        tests++;
                        if (lat < 2) begin
                            fails++;
                            $display("FAIL latency: got %0d edges expected at least 2", lat);
                        end
                        last_lat  = lat;
                        last_data = bus.res_data;
                        retired_tags.push_back(int'(bus.res_tag));
                    end
                end
`ifdef FMA_SCHED_STICKY_EN
                for (int i = 0; i < 2; i++) begin
                    if (flags_clr[i]) sticky_m[i] = 4'b0000;
                    if (hs && e[20] == 1'(i)) sticky_m[i] = sticky_m[i] | e[19:16];
                end
`endif
                stall_prev   = bus.res_valid && !bus.res_ready;
                dp_hold_prev = stall_prev && exp_q.size() == 2 && last_acc == 2'b00;
                held_prev    = {bus.res_data, bus.res_tag, bus.res_flags};
                dp_prev      = {dp_x, dp_y, dp_z, dp_ctl, dp_rm};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        sticky_m[0]   = 4'b0000;
        sticky_m[1]   = 4'b0000;
        bus.res_ready = 1'b1;
        flags_clr     = 2'b00;
        rand_op(0);
        rand_op(1);
        bus.req_valid = 2'b11;

        // reset state with both requesters asking
        @(negedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_res", 64'({bus.res_data, bus.res_tag, bus.res_flags}), 64'(0));
        check("rst_dp", 64'({dp_x, dp_y, dp_z, dp_ctl, dp_rm}), 64'(0));
        check("rst_sticky", 64'(sticky_flags), 64'(0));
        check("rst_occ", 64'(occ), 64'(OCC_EMPTY));
        @(negedge clk);

        // single op offered as reset releases
        reset_n = 1'b1;
        set_op(0, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, 2'b00);
        bus.req_valid = 2'b01;
        tick();
        check("first_accept", 64'(last_acc), 64'(2'b01));
        bus.req_valid = 2'b00;
        repeat (4) tick();
        check("single_latency", 64'(last_lat), 64'(2));
        check("single_data", 64'(last_data), 64'(16'h4200));
        drain("single_drain");

        // contention: both valid for 4 cycles
        retired_tags.delete();
        rand_op(0);
        rand_op(1);
        bus.req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int i = 0; i < 2; i++) if (last_acc[i]) rand_op(i);
        end
        drain("rr_drain");
        check("rr_count", 64'(retired_tags.size()), 64'(4));
        for (int k = 0; k < 4 && k < retired_tags.size(); k++)
            check("rr_tag", 64'(retired_tags[k]), 64'(k % 2));

        // backpressure: consumer stalled 5 cycles, requester keeps offering
        acc_cnt       = 0;
        bus.res_ready = 1'b0;
        rand_op(0);
        bus.req_valid = 2'b01;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (last_acc[0]) rand_op(0);
        end
        check("bp_accepts", 64'(acc_cnt), 64'(2));
        drain("bp_drain");

        // sticky flags
        flags_clr = 2'b11;
        tick();
        flags_clr = 2'b00;
        set_op(1, 16'h7BFF, 16'h4000, 16'h0000, 4'b1100, 2'b00);
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = 2'b00;
        repeat (4) tick();
        check("of_data", 64'(last_data), 64'(16'h7C00));
`ifdef FMA_SCHED_STICKY_EN
        check("sticky_of", 64'(sticky_flags[1]), 64'(4'b0101));
`else
        check("sticky_off", 64'(sticky_flags[1]), 64'(4'b0000));
`endif
        check("sticky_other", 64'(sticky_flags[0]), 64'(4'b0000));
        set_op(1, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, 2'b00);
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = 2'b00;
        n = 0;
        while (!bus.res_valid && n < 10) begin
            tick();
            n++;
        end
        check("clr_wait", 64'(bus.res_valid), 64'(1));
        flags_clr = 2'b10;
        tick();
        flags_clr = 2'b00;
        tick();
        check("sticky_clr", 64'(sticky_flags[1]), 64'(4'b0000));

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            bus.res_ready = ($urandom_range(0, 3) != 0);
            flags_clr     = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (!(bus.req_valid[i] && !last_acc[i])) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    rand_op(i);
                end
            end
            tick();
        end
        drain("rand_drain");

        // reset while the pipeline is full
        bus.res_ready = 1'b0;
        rand_op(0);
        bus.req_valid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (last_acc[0]) rand_op(0);
        end
        check("pre_reset_full", 64'(exp_q.size()), 64'(2));
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("mid_rst_dp", 64'({dp_x, dp_y, dp_z, dp_ctl, dp_rm}), 64'(0));
        check("mid_rst_res", 64'({bus.res_data, bus.res_tag, bus.res_flags}), 64'(0));
        check("mid_rst_sticky", 64'(sticky_flags), 64'(0));
        check("mid_rst_occ", 64'(occ), 64'(OCC_EMPTY));
        exp_q.delete();
        prio_m      = 0;
        sticky_m[0] = 4'b0000;
        sticky_m[1] = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset_n       = 1'b1;
        bus.req_valid = 2'b00;
        bus.res_ready = 1'b1;
        retired_tags.delete();
        repeat (6) tick();
        check("post_reset_retires", 64'(retired_tags.size()), 64'(0));
        set_op(1, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, 2'b00);
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = 2'b00;
        drain("post_reset_drain");
        check("post_reset_data", 64'(last_data), 64'(16'h4200));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
